// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: runs single-register I2C write/read transactions by driving the
// register interface of an I2C master controller (FDR/CR/SR/DR programming model).
module i2c_xfer_seq #(
    parameter logic [7:0]  FDR_VAL = 8'h00,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       i_sysclk,
    input  logic       i_reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_rw,
    input  logic [6:0] i_req_dev,
    input  logic [7:0] i_req_reg,
    input  logic [7:0] i_req_wdata,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_rdata,
    output logic [1:0] o_rsp_err,
    output logic       o_wr_ena,
    output logic [4:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_rd_ena,
    output logic [4:0] o_rd_addr,
    input  logic [7:0] i_rd_data
);

    localparam int unsigned STEP_W = 4;
    localparam int unsigned POLL_W = 16;
    localparam int unsigned LAT_W  = 8;

    localparam logic [4:0] ADDR_FDR = 5'h04;
    localparam logic [4:0] ADDR_CR  = 5'h08;
    localparam logic [4:0] ADDR_SR  = 5'h0C;
    localparam logic [4:0] ADDR_DR  = 5'h10;

    localparam logic [7:0] CR_IDLE   = 8'h80;
    localparam logic [7:0] CR_START  = 8'hB0;
    localparam logic [7:0] CR_RSTART = 8'hB4;
    localparam logic [7:0] CR_RX     = 8'hA8;

    localparam int unsigned SR_MAL  = 4;
    localparam int unsigned SR_MIF  = 1;
    localparam int unsigned SR_RXAK = 0;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_ARB  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [3:0] {
        RST, INIT_FDR, INIT_CR, IDLE, START, TX_BYTE, WAIT_RD, WAIT_SMP,
        CLR_IF, RSTART, SET_RX, DUMMY_RD, STOP, FINAL_RD, DONE
    } state_t;

    state_t              state, state_n;
    logic [STEP_W-1:0]   step, step_n;
    logic [POLL_W-1:0]   poll_cnt, poll_n;
    logic [LAT_W-1:0]    lat_cnt, lat_n;
    logic                rx_wait, rx_wait_n;
    logic                nack, nack_n;
    logic                rd_issued, rd_issued_n;
    logic                req_rw, rw_n;
    logic [6:0]          req_dev, dev_n;
    logic [7:0]          req_reg, reg_n;
    logic [7:0]          req_wdata, wdata_n;
    logic                ready_n, rsp_valid_n;
    logic [7:0]          rdata_n;
    logic [1:0]          err_n;
    logic                wr_ena_n, rd_ena_n;
    logic [4:0]          wr_addr_n, rd_addr_n;
    logic [7:0]          wr_data_n;
    logic                strobe_busy;

    // State that performs a given step of the transaction program.
    function automatic state_t step_state(input logic [STEP_W-1:0] s, input logic rw);
        case (s)
            4'd0:       step_state = START;
            4'd1, 4'd2: step_state = TX_BYTE;
            4'd3:       step_state = rw ? RSTART   : TX_BYTE;
            4'd4:       step_state = rw ? TX_BYTE  : STOP;
            4'd5:       step_state = rw ? SET_RX   : DONE;
            4'd6:       step_state = rw ? DUMMY_RD : DONE;
            4'd7:       step_state = rw ? STOP     : DONE;
            4'd8:       step_state = rw ? FINAL_RD : DONE;
            default:    step_state = DONE;
        endcase
    endfunction

    function automatic logic [7:0] tx_byte(input logic [STEP_W-1:0] s, input logic [6:0] dev,
                                           input logic [7:0] rg, input logic [7:0] wd);
        case (s)
            4'd1:    tx_byte = {dev, 1'b0};
            4'd2:    tx_byte = rg;
            4'd3:    tx_byte = wd;
            4'd4:    tx_byte = {dev, 1'b1};
            default: tx_byte = 8'h00;
        endcase
    endfunction

    // A strobe issued last cycle is still visible; hold off to leave an idle gap.
    assign strobe_busy = o_wr_ena | o_rd_ena;

    always_comb begin
        state_n     = state;
        step_n      = step;
        poll_n      = poll_cnt;
        lat_n       = lat_cnt;
        rx_wait_n   = rx_wait;
        nack_n      = nack;
        rd_issued_n = rd_issued;
        rw_n        = req_rw;
        dev_n       = req_dev;
        reg_n       = req_reg;
        wdata_n     = req_wdata;
        ready_n     = 1'b0;
        rsp_valid_n = 1'b0;
        rdata_n     = o_rsp_rdata;
        err_n       = o_rsp_err;
        wr_ena_n    = 1'b0;
        wr_addr_n   = o_wr_addr;
        wr_data_n   = o_wr_data;
        rd_ena_n    = 1'b0;
        rd_addr_n   = o_rd_addr;

        case (state)
            RST: state_n = INIT_FDR;
            INIT_FDR: if (!strobe_busy) begin
                wr_ena_n = 1'b1; wr_addr_n = ADDR_FDR; wr_data_n = FDR_VAL;
                state_n  = INIT_CR;
            end
            INIT_CR: if (!strobe_busy) begin
                wr_ena_n = 1'b1; wr_addr_n = ADDR_CR; wr_data_n = CR_IDLE;
                state_n  = IDLE;
            end
            IDLE: begin
                ready_n = 1'b1;
                if (o_req_ready && i_req_valid) begin
                    ready_n = 1'b0;
                    rw_n    = i_req_rw;
                    dev_n   = i_req_dev;
                    reg_n   = i_req_reg;
                    wdata_n = i_req_wdata;
                    err_n   = ERR_OK;
                    nack_n  = 1'b0;
                    step_n  = '0;
                    state_n = START;
                end
            end
            START, RSTART, SET_RX: if (!strobe_busy) begin
                wr_ena_n  = 1'b1;
                wr_addr_n = ADDR_CR;
                wr_data_n = (state == START) ? CR_START : (state == RSTART) ? CR_RSTART : CR_RX;
                step_n    = STEP_W'(step + 4'd1);
                state_n   = step_state(STEP_W'(step + 4'd1), req_rw);
            end
            TX_BYTE: if (!strobe_busy) begin
                wr_ena_n  = 1'b1;
                wr_addr_n = ADDR_DR;
                wr_data_n = tx_byte(step, req_dev, req_reg, req_wdata);
                step_n    = STEP_W'(step + 4'd1);
                poll_n    = '0;
                rx_wait_n = 1'b0;
                state_n   = WAIT_RD;
            end
            DUMMY_RD: if (!strobe_busy) begin
                rd_ena_n  = 1'b1;
                rd_addr_n = ADDR_DR;
                step_n    = STEP_W'(step + 4'd1);
                poll_n    = '0;
                rx_wait_n = 1'b1;
                state_n   = WAIT_RD;
            end
            WAIT_RD: if (!strobe_busy) begin
                rd_ena_n  = 1'b1;
                rd_addr_n = ADDR_SR;
                lat_n     = '0;
                state_n   = WAIT_SMP;
            end
            // Status is valid RD_LAT cycles after the read strobe.
            WAIT_SMP: begin
                if (32'(lat_cnt) == RD_LAT) begin
                    if (i_rd_data[SR_MAL]) begin
                        err_n   = ERR_ARB;
                        state_n = DONE;
                    end else if (i_rd_data[SR_MIF]) begin
                        nack_n  = !rx_wait && i_rd_data[SR_RXAK];
                        state_n = CLR_IF;
                    end else begin
                        poll_n = (poll_cnt == {POLL_W{1'b1}}) ? poll_cnt : POLL_W'(poll_cnt + 16'd1);
                        if (32'(poll_cnt) + 32'd1 >= TIMEOUT) begin
                            err_n   = ERR_TMO;
                            state_n = STOP;
                        end else begin
                            state_n = WAIT_RD;
                        end
                    end
                end else begin
                    lat_n = LAT_W'(lat_cnt + 8'd1);
                end
            end
            CLR_IF: if (!strobe_busy) begin
                wr_ena_n  = 1'b1;
                wr_addr_n = ADDR_SR;
                wr_data_n = 8'h00;
                if (nack) begin
                    err_n   = ERR_NACK;
                    nack_n  = 1'b0;
                    state_n = STOP;
                end else begin
                    state_n = step_state(step, req_rw);
                end
            end
            STOP: if (!strobe_busy) begin
                wr_ena_n  = 1'b1;
                wr_addr_n = ADDR_CR;
                wr_data_n = CR_IDLE;
                if (o_rsp_err != ERR_OK) begin
                    state_n = DONE;
                end else begin
                    step_n  = STEP_W'(step + 4'd1);
                    state_n = step_state(STEP_W'(step + 4'd1), req_rw);
                end
            end
            FINAL_RD: begin
                if (!rd_issued) begin
                    if (!strobe_busy) begin
                        rd_ena_n    = 1'b1;
                        rd_addr_n   = ADDR_DR;
                        rd_issued_n = 1'b1;
                        lat_n       = '0;
                    end
                end else if (32'(lat_cnt) == RD_LAT) begin
                    rdata_n     = i_rd_data;
                    rd_issued_n = 1'b0;
                    state_n     = DONE;
                end else begin
                    lat_n = LAT_W'(lat_cnt + 8'd1);
                end
            end
            DONE: begin
                rsp_valid_n = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = RST;
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            state       <= RST;
            step        <= '0;
            poll_cnt    <= '0;
            lat_cnt     <= '0;
            rx_wait     <= 1'b0;
            nack        <= 1'b0;
            rd_issued   <= 1'b0;
            req_rw      <= 1'b0;
            req_dev     <= '0;
            req_reg     <= '0;
            req_wdata   <= '0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 8'h00;
            o_rsp_err   <= ERR_OK;
            o_wr_ena    <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_rd_ena    <= 1'b0;
            o_rd_addr   <= '0;
        end else begin
            state       <= state_n;
            step        <= step_n;
            poll_cnt    <= poll_n;
            lat_cnt     <= lat_n;
            rx_wait     <= rx_wait_n;
            nack        <= nack_n;
            rd_issued   <= rd_issued_n;
            req_rw      <= rw_n;
            req_dev     <= dev_n;
            req_reg     <= reg_n;
            req_wdata   <= wdata_n;
            o_req_ready <= ready_n;
            o_rsp_valid <= rsp_valid_n;
            o_rsp_rdata <= rdata_n;
            o_rsp_err   <= err_n;
            o_wr_ena    <= wr_ena_n;
            o_wr_addr   <= wr_addr_n;
            o_wr_data   <= wr_data_n;
            o_rd_ena    <= rd_ena_n;
            o_rd_addr   <= rd_addr_n;
        end
    end

endmodule
